// File: rtl/calc_pkg.sv
// Shared opcode constants and FSM state type for the calculator sequencer.
package calc_pkg;

   localparam logic [2:0] OP_CLEAR = 3'b000;
   localparam logic [2:0] OP_ADD   = 3'b001;
   localparam logic [2:0] OP_SUB   = 3'b010;
   localparam logic [2:0] OP_DISP  = 3'b011;
   localparam logic [2:0] OP_LOAD  = 3'b100;
   localparam logic [2:0] OP_IDLE  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   // Opcodes 000..100 do real work; IDLE and the reserved codes are ignored.
   function automatic logic is_exec_op(input logic [2:0] op);
      return (op <= OP_LOAD);
   endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational add/subtract unit with carry/borrow and signed overflow.
module calc_alu #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf
);

   logic [WIDTH:0] sum_ext;

   // Extending by one bit gives the add carry-out, and for subtraction the top bit is the borrow.
   always_comb begin
      if (sub) begin
         sum_ext = {1'b0, a} - {1'b0, b};
      end else begin
         sum_ext = {1'b0, a} + {1'b0, b};
      end
      result = sum_ext[WIDTH-1:0];
      carry  = sum_ext[WIDTH];
      if (sub) begin
         ovf = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end else begin
         ovf = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
   end

endmodule

// File: rtl/calc_sequencer.sv
// Three-state keyboard instruction sequencer: accept, execute, write back.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [2:0]       instr,
   input  logic [WIDTH-1:0] operand,
   output logic             busy,
   output logic [WIDTH-1:0] acc,
   output logic             carry,
   output logic             ovf,
   output logic [WIDTH-1:0] disp_data,
   output logic             disp_valid,
   output logic             drop_err,
   output logic [7:0]       op_count
);

   state_t           state;
   state_t           next_state;
   logic             accept;
   logic             drop;
   logic [2:0]       op_reg;
   logic [WIDTH-1:0] operand_reg;
   logic [WIDTH-1:0] res_acc;
   logic             res_carry;
   logic             res_ovf;
   logic             alu_sub;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             alu_ovf;

   assign busy    = (state != S_IDLE);
   assign alu_sub = (op_reg == OP_SUB);

   calc_alu #(.WIDTH(WIDTH)) u_alu (
      .a      (acc),
      .b      (operand_reg),
      .sub    (alu_sub),
      .result (alu_result),
      .carry  (alu_carry),
      .ovf    (alu_ovf)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state, acceptance of a new instruction, and discard of strobes while busy.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      drop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (instr_valid && is_exec_op(instr)) begin
               accept     = 1'b1;
               next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            drop       = instr_valid;
            next_state = S_WB;
         end
         S_WB: begin
            drop       = instr_valid;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Datapath: latch on accept, register results in EXEC, commit to outputs in WB.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_reg      <= OP_CLEAR;
         operand_reg <= '0;
         res_acc     <= '0;
         res_carry   <= 1'b0;
         res_ovf     <= 1'b0;
         acc         <= '0;
         carry       <= 1'b0;
         ovf         <= 1'b0;
         disp_data   <= '0;
         disp_valid  <= 1'b0;
         drop_err    <= 1'b0;
         op_count    <= 8'd0;
      end else begin
         disp_valid <= 1'b0;
         drop_err   <= drop;
         if (accept) begin
            op_reg      <= instr;
            operand_reg <= operand;
         end
         if (state == S_EXEC) begin
            case (op_reg)
               OP_CLEAR: begin
                  res_acc   <= '0;
                  res_carry <= 1'b0;
                  res_ovf   <= 1'b0;
               end
               OP_ADD, OP_SUB: begin
                  res_acc   <= alu_result;
                  res_carry <= alu_carry;
                  res_ovf   <= alu_ovf;
               end
               OP_LOAD: begin
                  res_acc   <= operand_reg;
                  res_carry <= carry;
                  res_ovf   <= ovf;
               end
               default: begin
                  res_acc   <= acc;
                  res_carry <= carry;
                  res_ovf   <= ovf;
               end
            endcase
         end
         if (state == S_WB) begin
            acc      <= res_acc;
            carry    <= res_carry;
            ovf      <= res_ovf;
            op_count <= op_count + 8'd1;
            if (op_reg == OP_DISP) begin
               disp_data  <= acc;
               disp_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, sets the accumulator/operand width in bits.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 instr_valid  input  1  one-cycle strobe: instr holds a new keyboard instruction.
REQ-005 instr  input  3  opcode: 000 CLEAR, 001 ADD, 010 SUB, 011 DISP, 100 LOAD, 101 IDLE; 110/111 reserved.
REQ-006 operand  input  WIDTH  operand value, sampled only when an instruction is accepted.
REQ-007 busy  output  1  high while an accepted instruction is in flight.
REQ-008 acc  output  WIDTH  accumulator value.
REQ-009 carry  output  1  ADD carry-out, or SUB borrow, of the last arithmetic op.
REQ-010 ovf  output  1  signed overflow of the last arithmetic op.
REQ-011 disp_data  output  WIDTH  value captured by the last DISP.
REQ-012 disp_valid  output  1  one-cycle pulse when disp_data updates.
REQ-013 drop_err  output  1  one-cycle pulse when a strobe is discarded because the block is busy.
REQ-014 op_count  output  8  count of completed instructions, modulo 256.

Function
REQ-015 The FSM SHALL have exactly three states: S_IDLE, S_EXEC and S_WB.
REQ-016 In S_IDLE, instr_valid=1 with opcode 000-100 SHALL latch opcode and operand and move the FSM to S_EXEC.
REQ-017 In S_IDLE, instr_valid=1 with opcode 101, 110 or 111 SHALL be ignored: no state change, no busy, no drop_err, no op_count change.
REQ-018 S_EXEC SHALL register the ALU result and flags, then move to S_WB unconditionally.
REQ-019 S_WB SHALL commit the results to the outputs, increment op_count, and return to S_IDLE unconditionally.
REQ-020 Latency: for a strobe accepted at edge E0, acc, carry, ovf, disp_data and disp_valid SHALL update at edge E0+2.
REQ-021 busy SHALL equal (state != S_IDLE), i.e. high for exactly 2 cycles per accepted instruction.
REQ-022 A strobe arriving while busy=1, including the S_WB cycle, SHALL be discarded and pulse drop_err for 1 cycle; back-to-back acceptance needs ≥1 idle cycle.
REQ-023 CLEAR SHALL write acc=0, carry=0 and ovf=0.
REQ-024 LOAD SHALL write acc=operand and leave carry and ovf unchanged.
REQ-025 ADD SHALL write acc=(acc+operand) mod 2^WIDTH, carry=bit WIDTH of the sum, and ovf=1 iff both inputs share a sign differing from the result sign.
REQ-026 SUB SHALL write acc=(acc-operand) mod 2^WIDTH, carry=1 iff operand>acc unsigned (borrow), and ovf=1 iff the input signs differ and the result sign differs from acc's sign.
REQ-027 DISP SHALL write disp_data=acc and pulse disp_valid at E0+2, and leave acc, carry and ovf unchanged.
REQ-028 The ALU SHALL use the acc value present at acceptance; acc cannot change during the operation because only S_WB writes it.
REQ-029 op_count SHALL wrap from 255 to 0 without any flag.
REQ-030 disp_valid and drop_err SHALL be low in every cycle not specified above.

Reset
REQ-031 When rst=1 at a clock edge, the FSM SHALL go to S_IDLE, and acc, carry, ovf, disp_data, disp_valid, drop_err, op_count and busy SHALL be 0.
REQ-032 Reset SHALL take priority over instr_valid in the same cycle.
REQ-033 Reset in S_EXEC or S_WB SHALL abort the instruction: no commit, no disp_valid, no op_count increment.

Structure
REQ-034 Package calc_pkg SHALL hold the opcode constants (values per REQ-005) and the FSM state type.
REQ-035 Sub-module calc_alu SHALL be the combinational WIDTH-bit add/sub unit with carry and ovf outputs; calc_sequencer owns all registers.
REQ-036 No other sub-modules.

Verification
REQ-037 Reset; LOAD 0x7F; ADD 0x01 -> acc=0x80, carry=0, ovf=1, op_count=2.
REQ-038 LOAD 0x05; SUB 0x06 -> acc=0xFF, carry=1, ovf=0; LOAD 0xFF; ADD 0x01 -> acc=0x00, carry=1, ovf=0.
REQ-039 LOAD 0x3C; DISP -> disp_valid pulses exactly once, 2 cycles after acceptance, with disp_data=0x3C and acc=0x3C.
REQ-040 Strobes at cycles N, N+1 and N+2 -> only N executes; drop_err pulses at N+1 and N+2; a strobe at N+3 is accepted.
REQ-041 Opcodes 101/110/111 strobed -> busy stays 0, outputs and op_count unchanged; 256 CLEARs from reset -> op_count=0.
REQ-042 rst asserted while in S_EXEC of ADD after LOAD 0x10 -> all outputs 0 next cycle, no disp_valid, and a subsequent LOAD is accepted normally.
